smear_sequencer: RTL and testbench
==================================

// Module: smear_sequencer
// PURPOSE
//  Control FSM that runs one SAM insert/search op across the group array. Sequence: compare, smear
//  (drives the GroupSmear controls), then shift. Latches item format (hINDX vs hPAGE/hBOOK) per op.
//  Tracks group occupancy and drives the per-group stop vector. Sits between the command front-end
//  and the group datapath.
// PARAMETERS
//  GROUP_CNT  16  number of groups; width of overTgt/stop/grpMask
//  CMP_TMO    15  max cycles waiting for cmpDone before error (4-bit timer)
//  SHF_TMO    63  max cycles waiting for shiftDone before error (6-bit timer)
// PORTS
//  clk        in   1          single clock, rising edge
//  rstN       in   1          asynchronous, active-low reset
//  reqValid   in   1          op request; accepted when reqValid & reqRdy
//  reqRdy     out  1          1 only in IDLE
//  reqOp      in   1          0=search, 1=insert
//  reqInx     in   1          1=hPAGE/hBOOK (3 groups/item), 0=hINDX (2 groups/item)
//  clrCnt     in   1          clear occupancy (honoured only in IDLE)
//  cmpGo      out  1          1-cycle pulse: groups start compare
//  cmpDone    in   1          grpRslt valid
//  smearGo    out  1          to GroupSmear
//  setBit     out  1          to GroupSmear
//  inxBit     out  1          to GroupSmear; latched reqInx, stable for whole op
//  stop       out  GROUP_CNT  to GroupSmear; stop[g]=1 for g >= usedGrps
//  shiftGo    out  1          1-cycle pulse: shift grpMask-selected groups
//  shiftDone  in   1          shift complete
//  done       out  1          1-cycle pulse at op end
//  status     out  2          valid with done: 0=OK 1=FULL 2=CMP_TMO 3=SHF_TMO
//  usedGrps   out  $clog2(GROUP_CNT+1)  groups occupied
// BEHAVIOUR
//  Reset: state=IDLE; reqRdy=1; usedGrps=0; stop=all 1s; inxBit=0; all pulses and status=0.
//  States: IDLE, CMP, SMEAR, SETTLE, SHIFT, DONE.
//  IDLE: on accept, latch op/inx.
//   - Insert when usedGrps+gpi > GROUP_CNT (gpi=3 if inx, else 2): go to DONE with FULL;
//     no cmpGo is issued.
//   - Otherwise pulse cmpGo in the accept cycle+1 (registered) and enter CMP.
//  CMP: wait for cmpDone, then go to SMEAR. Timer counts cycles in CMP; reaching CMP_TMO with no
//   cmpDone goes to DONE with CMP_TMO. cmpDone on the timeout cycle wins (OK).
//  SMEAR: exactly one cycle with smearGo=setBit=1, then SETTLE. smearGo=setBit=0 in all other
//   states.
//  SETTLE: one cycle so the registered grpMask is valid. Then search goes to DONE OK; insert
//   pulses shiftGo and enters SHIFT.
//  SHIFT: wait for shiftDone, then go to DONE OK and do usedGrps += gpi. Timeout at SHF_TMO goes
//   to DONE with SHF_TMO; count is unchanged.
//  DONE: done=1 for one cycle with status, then IDLE.
//  Latency for a search with cmpDone at first CMP cycle: accept -> done = 4 cycles.
//  stop is recomputed from usedGrps with registered output; it reflects new usedGrps one cycle
//  after the update, before the next accept.
//  clrCnt outside IDLE is ignored. clrCnt together with an accept in IDLE: clear takes effect
//  first, so the FULL check uses 0.
//  Stray cmpDone/shiftDone in other states is ignored.
//  rstN low mid-op: immediate return to reset values; no done pulse.
//  usedGrps never exceeds GROUP_CNT (guaranteed by the FULL check); arithmetic uses width+1 bits.
// STRUCTURE
//  Shared package sam_seq_pkg: state enum seqState_t, status enum seqStatus_t, constants
//  GPI_INDX=2, GPI_PAGE=3.
//  One sub-module, stop_gen: combinational usedGrps -> thermometer stop vector, registered here.
//  Timer is shared by CMP and SHIFT and cleared on state entry.
// TESTING
//  1 Reset: rstN=0 -> reqRdy=1, usedGrps=0, stop=16'hFFFF, no pulses.
//  2 Insert hINDX, cmpDone 2 cycles after cmpGo, shiftDone 3 cycles after shiftGo -> one
//    smearGo/setBit cycle with inxBit=0; done status=OK; usedGrps=2; stop=16'hFFFC.
//  3 Search inx=1 -> no shiftGo; done status=OK; usedGrps unchanged; inxBit=1 during SMEAR.
//  4 Five hPAGE inserts: usedGrps=15. Sixth -> done status=FULL with no cmpGo.
//    hINDX then -> FULL (17>16).
//  5 cmpDone withheld -> done status=CMP_TMO exactly CMP_TMO cycles after CMP entry; no smearGo.
//    Repeat for shift -> SHF_TMO, count unchanged.
//  6 rstN pulse while in SHIFT -> all outputs return to reset values asynchronously.
//    clrCnt+accept in IDLE -> FULL check uses 0.

Source files
------------

// File: rtl/sam_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sam_seq_pkg                                                      |
// | Brief   : Shared states, status codes and item geometry for the SAM        |
// |           smear sequencer.                                                 |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package sam_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMP    = 3'd1,
        ST_SMEAR  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_SHIFT  = 3'd4,
        ST_DONE   = 3'd5
    } seqState_t;

    typedef enum logic [1:0] {
        STS_OK      = 2'd0,
        STS_FULL    = 2'd1,
        STS_CMP_TMO = 2'd2,
        STS_SHF_TMO = 2'd3
    } seqStatus_t;

    localparam int GPI_INDX = 2;
    localparam int GPI_PAGE = 3;

    // Groups consumed by one item: hPAGE/hBOOK items span three groups.
    function automatic logic [1:0] gpiOf(input logic inx);
        return inx ? 2'(GPI_PAGE) : 2'(GPI_INDX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/smear_sequencer_stop_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : stop_gen                                                         |
// | Brief   : Thermometer decode of occupied group count into the stop vector. |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module stop_gen #(
    parameter int GROUP_CNT = 16,
    parameter int CNT_W     = 5
) (
    input  logic [CNT_W-1:0]     usedGrps,
    output logic [GROUP_CNT-1:0] stopVec
);

    // Every group at or beyond the occupied boundary is told to stop.
    for (genvar g = 0; g < GROUP_CNT; g++) begin : g_stop
        assign stopVec[g] = ((CNT_W+1)'(g) >= {1'b0, usedGrps});
    end

endmodule
`default_nettype wire

// File: rtl/smear_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : smear_sequencer                                                  |
// | Brief   : Runs one SAM insert/search op: compare, smear, settle, shift.    |
// |           Tracks group occupancy and drives the per-group stop vector.     |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module smear_sequencer
    import sam_seq_pkg::*;
#(
    parameter int GROUP_CNT = 16,
    parameter int CMP_TMO   = 15,
    parameter int SHF_TMO   = 63
) (
    input  logic                           clk,
    input  logic                           rstN,
    input  logic                           reqValid,
    output logic                           reqRdy,
    input  logic                           reqOp,
    input  logic                           reqInx,
    input  logic                           clrCnt,
    output logic                           cmpGo,
    input  logic                           cmpDone,
    output logic                           smearGo,
    output logic                           setBit,
    output logic                           inxBit,
    output logic [GROUP_CNT-1:0]           stop,
    output logic                           shiftGo,
    input  logic                           shiftDone,
    output logic                           done,
    output logic [1:0]                     status,
    output logic [$clog2(GROUP_CNT+1)-1:0] usedGrps
);

    localparam int c_cntW   = $clog2(GROUP_CNT + 1);
    localparam int c_arithW = c_cntW + 1;
    localparam int c_tmrW   = 6;

    localparam logic [c_tmrW-1:0]   c_cmpLast = c_tmrW'(CMP_TMO - 1);
    localparam logic [c_tmrW-1:0]   c_shfLast = c_tmrW'(SHF_TMO - 1);
    localparam logic [c_arithW-1:0] c_grpCnt  = c_arithW'(GROUP_CNT);

    seqState_t             r_state;
    logic                  r_isInsert;
    logic [c_tmrW-1:0]     r_timer;

    logic [c_arithW-1:0]   w_base;
    logic [c_arithW-1:0]   w_reqSum;
    logic                  w_full;
    logic [GROUP_CNT-1:0]  w_stopNext;

    // A clear issued alongside an accept counts as already applied.
    assign w_base   = clrCnt ? '0 : {1'b0, usedGrps};
    assign w_reqSum = w_base + c_arithW'(gpiOf(reqInx));
    assign w_full   = reqOp && (w_reqSum > c_grpCnt);

    stop_gen #(
        .GROUP_CNT (GROUP_CNT),
        .CNT_W     (c_cntW)
    ) u_stopGen (
        .usedGrps (usedGrps),
        .stopVec  (w_stopNext)
    );

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state    <= ST_IDLE;
            r_isInsert <= 1'b0;
            r_timer    <= '0;
            reqRdy     <= 1'b1;
            usedGrps   <= '0;
            stop       <= '1;
            inxBit     <= 1'b0;
            cmpGo      <= 1'b0;
            smearGo    <= 1'b0;
            setBit     <= 1'b0;
            shiftGo    <= 1'b0;
            done       <= 1'b0;
            status     <= STS_OK;
        end else begin
            cmpGo   <= 1'b0;
            smearGo <= 1'b0;
            setBit  <= 1'b0;
            shiftGo <= 1'b0;
            done    <= 1'b0;
            stop    <= w_stopNext;

            case (r_state)
                ST_IDLE: begin
                    if (clrCnt) usedGrps <= '0;
                    if (reqValid) begin
                        reqRdy     <= 1'b0;
                        r_isInsert <= reqOp;
                        inxBit     <= reqInx;
                        if (w_full) begin
                            r_state <= ST_DONE;
                            done    <= 1'b1;
                            status  <= STS_FULL;
                        end else begin
                            r_state <= ST_CMP;
                            cmpGo   <= 1'b1;
                            r_timer <= '0;
                        end
                    end
                end
                ST_CMP: begin
                    if (cmpDone) begin
                        r_state <= ST_SMEAR;
                        smearGo <= 1'b1;
                        setBit  <= 1'b1;
                    end else if (r_timer == c_cmpLast) begin
                        r_state <= ST_DONE;
                        done    <= 1'b1;
                        status  <= STS_CMP_TMO;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_SMEAR: begin
                    r_state <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (r_isInsert) begin
                        r_state <= ST_SHIFT;
                        shiftGo <= 1'b1;
                        r_timer <= '0;
                    end else begin
                        r_state <= ST_DONE;
                        done    <= 1'b1;
                        status  <= STS_OK;
                    end
                end
                ST_SHIFT: begin
                    if (shiftDone) begin
                        r_state  <= ST_DONE;
                        done     <= 1'b1;
                        status   <= STS_OK;
                        usedGrps <= usedGrps + c_cntW'(gpiOf(inxBit));
                    end else if (r_timer == c_shfLast) begin
                        r_state <= ST_DONE;
                        done    <= 1'b1;
                        status  <= STS_SHF_TMO;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    reqRdy  <= 1'b1;
                    status  <= STS_OK;
                end
                default: begin
                    r_state <= ST_IDLE;
                    reqRdy  <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_smear_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_smear_sequencer                                               |
// | Brief   : Directed self-checking bench for smear_sequencer.                |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_smear_sequencer;

    logic        clk = 1'b0;
    logic        rstN;
    logic        reqValid, reqRdy, reqOp, reqInx, clrCnt;
    logic        cmpGo, cmpDone, smearGo, setBit, inxBit;
    logic [15:0] stop;
    logic        shiftGo, shiftDone, done;
    logic [1:0]  status;
    logic [4:0]  usedGrps;

    int checks = 0;
    int errors = 0;

    int         cmpGoCnt, smearCnt, shiftCnt, setMis, doneAt;
    logic       smearInx, doneLow, rdyAfter;
    logic [1:0] doneSts;

    smear_sequencer #(
        .GROUP_CNT (16),
        .CMP_TMO   (15),
        .SHF_TMO   (63)
    ) dut (
        .clk       (clk),
        .rstN      (rstN),
        .reqValid  (reqValid),
        .reqRdy    (reqRdy),
        .reqOp     (reqOp),
        .reqInx    (reqInx),
        .clrCnt    (clrCnt),
        .cmpGo     (cmpGo),
        .cmpDone   (cmpDone),
        .smearGo   (smearGo),
        .setBit    (setBit),
        .inxBit    (inxBit),
        .stop      (stop),
        .shiftGo   (shiftGo),
        .shiftDone (shiftDone),
        .done      (done),
        .status    (status),
        .usedGrps  (usedGrps)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issues one request; cmpDone/shiftDone are returned dly cycles after the
    // respective go pulse (negative = never). Cycle 0 is the accept cycle.
    task automatic doOp(input logic op, input logic inx, input logic clr,
                        input int cmpDly, input int shfDly);
        int cmpAt = -1;
        int shfAt = -1;
        cmpGoCnt = 0; smearCnt = 0; shiftCnt = 0; setMis = 0;
        doneAt = -1; doneSts = 2'd0; smearInx = 1'b0;
        @(negedge clk);
        reqValid = 1'b1; reqOp = op; reqInx = inx; clrCnt = clr;
        cmpDone = 1'b0; shiftDone = 1'b0;
        for (int cyc = 1; cyc < 200; cyc++) begin
            @(negedge clk);
            reqValid = 1'b0; clrCnt = 1'b0; cmpDone = 1'b0; shiftDone = 1'b0;
            if (setBit !== smearGo) setMis++;
            if (cmpGo)   begin cmpGoCnt++; cmpAt = cyc; end
            if (smearGo) begin smearCnt++; smearInx = inxBit; end
            if (shiftGo) begin shiftCnt++; shfAt = cyc; end
            if (done) begin
                doneAt  = cyc;
                doneSts = status;
                break;
            end
            if (cmpDly >= 0 && cmpAt >= 0 && cyc == cmpAt + cmpDly) cmpDone = 1'b1;
            if (shfDly >= 0 && shfAt >= 0 && cyc == shfAt + shfDly) shiftDone = 1'b1;
        end
        if (doneAt < 0) begin
            checks++;
            errors++;
            $error("FAIL op_bound: observed=no done expected=done within 200 cycles");
        end
        @(negedge clk);
        doneLow  = !done;
        rdyAfter = reqRdy;
    endtask

    initial begin
        rstN = 1'b0; reqValid = 1'b0; reqOp = 1'b0; reqInx = 1'b0;
        clrCnt = 1'b0; cmpDone = 1'b0; shiftDone = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_reqRdy", reqRdy, 1);
        chk("rst_used", usedGrps, 0);
        chk("rst_stop", stop, 16'hFFFF);
        chk("rst_inx", inxBit, 0);
        chk("rst_pulses", {cmpGo, smearGo, setBit, shiftGo, done}, 0);
        chk("rst_status", status, 0);
        rstN = 1'b1;
        @(negedge clk);

        // Insert hINDX, cmpDone +2, shiftDone +3
        doOp(1'b1, 1'b0, 1'b0, 2, 3);
        chk("ins_doneAt", doneAt, 10);
        chk("ins_status", doneSts, 0);
        chk("ins_cmpGo", cmpGoCnt, 1);
        chk("ins_smear", smearCnt, 1);
        chk("ins_setBit", setMis, 0);
        chk("ins_smearInx", smearInx, 0);
        chk("ins_shiftGo", shiftCnt, 1);
        chk("ins_used", usedGrps, 2);
        chk("ins_stop", stop, 16'hFFFC);
        chk("ins_donePulse", doneLow, 1);
        chk("ins_rdy", rdyAfter, 1);

        // Search hPAGE, cmpDone in first CMP cycle
        doOp(1'b0, 1'b1, 1'b0, 0, 0);
        chk("srch_doneAt", doneAt, 4);
        chk("srch_status", doneSts, 0);
        chk("srch_shiftGo", shiftCnt, 0);
        chk("srch_smearInx", smearInx, 1);
        chk("srch_used", usedGrps, 2);

        // Standalone clear
        @(negedge clk); clrCnt = 1'b1;
        @(negedge clk); clrCnt = 1'b0;
        chk("clr_used", usedGrps, 0);
        @(negedge clk);
        chk("clr_stop", stop, 16'hFFFF);

        // Fill with hPAGE items
        for (int k = 1; k <= 5; k++) begin
            doOp(1'b1, 1'b1, 1'b0, 0, 0);
            chk("fill_status", doneSts, 0);
            chk("fill_used", usedGrps, 3 * k);
        end
        chk("fill_doneAt", doneAt, 5);
        chk("fill_stop", stop, 16'h8000);

        doOp(1'b1, 1'b1, 1'b0, 0, 0);
        chk("full_page_status", doneSts, 1);
        chk("full_page_doneAt", doneAt, 1);
        chk("full_page_cmpGo", cmpGoCnt, 0);
        chk("full_page_used", usedGrps, 15);

        doOp(1'b1, 1'b0, 1'b0, 0, 0);
        chk("full_indx_status", doneSts, 1);
        chk("full_indx_cmpGo", cmpGoCnt, 0);
        chk("full_indx_used", usedGrps, 15);

        // Compare timeout
        doOp(1'b0, 1'b0, 1'b0, -1, 0);
        chk("cmptmo_status", doneSts, 2);
        chk("cmptmo_doneAt", doneAt, 16);
        chk("cmptmo_smear", smearCnt, 0);

        // cmpDone on the timeout cycle wins
        doOp(1'b0, 1'b0, 1'b0, 14, 0);
        chk("cmpedge_status", doneSts, 0);
        chk("cmpedge_doneAt", doneAt, 18);
        chk("cmpedge_smear", smearCnt, 1);

        // clrCnt together with accept: FULL check sees 0
        doOp(1'b1, 1'b1, 1'b1, 0, 0);
        chk("clracc_status", doneSts, 0);
        chk("clracc_cmpGo", cmpGoCnt, 1);
        chk("clracc_used", usedGrps, 3);

        // Shift timeout leaves the count unchanged
        doOp(1'b1, 1'b0, 1'b0, 0, -1);
        chk("shftmo_status", doneSts, 3);
        chk("shftmo_doneAt", doneAt, 67);
        chk("shftmo_used", usedGrps, 3);
        chk("shftmo_stop", stop, 16'hFFF8);

        // Asynchronous reset while in SHIFT
        @(negedge clk); reqValid = 1'b1; reqOp = 1'b1; reqInx = 1'b1;
        @(negedge clk); reqValid = 1'b0; cmpDone = 1'b1;
        @(negedge clk); cmpDone = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("arst_inShift", shiftGo, 1);
        @(negedge clk);
        #2 rstN = 1'b0;
        #1;
        chk("arst_reqRdy", reqRdy, 1);
        chk("arst_used", usedGrps, 0);
        chk("arst_stop", stop, 16'hFFFF);
        chk("arst_inx", inxBit, 0);
        chk("arst_pulses", {cmpGo, smearGo, setBit, shiftGo, done}, 0);
        chk("arst_status", status, 0);
        @(negedge clk); rstN = 1'b1;
        @(negedge clk);
        chk("arst_noDone", done, 0);
        chk("arst_idle", reqRdy, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
